// File: rtl/mem_arbiter.sv
// Round-robin arbiter that serialises per-core read/write requests onto a
// single memory port. One transaction is in flight at a time:
//   IDLE -> ISSUE -> WAIT (reads only, READ_LATENCY cycles) -> RESPOND -> IDLE
// The memory-side strobes, address and write data are registered, so they
// appear in the ISSUE cycle that follows the grant edge.
module mem_arbiter #(
    parameter int WIDTH        = 32,
    parameter int CORE_NUM     = 4,
    parameter int READ_LATENCY = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CORE_NUM-1:0]       req_bus,
    input  logic [CORE_NUM-1:0]       wren_bus,
    input  logic [CORE_NUM*WIDTH-1:0] addr_bus,
    input  logic [CORE_NUM*WIDTH-1:0] wdata_bus,
    output logic [CORE_NUM-1:0]       response_bus,
    output logic [WIDTH-1:0]          readdata,
    output logic [WIDTH-1:0]          mem_addr,
    output logic [WIDTH-1:0]          mem_wdata,
    output logic                      mem_wren,
    output logic                      mem_rden,
    input  logic [WIDTH-1:0]          mem_rdata
);

    localparam int ID_W = $clog2(CORE_NUM);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESPOND
    } state_t;

    state_t              state;
    state_t              state_d;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     cur_id;
    logic [ID_W-1:0]     next_ptr;
    logic [ID_W-1:0]     grant_id;
    logic [ID_W-1:0]     scan_idx;
    logic                grant_valid;
    logic                cur_wr;
    logic                wait_last;
    logic [2:0]          wait_cnt;
    logic [CORE_NUM-1:0] cool_mask;
    logic [CORE_NUM-1:0] eligible;
    logic [CORE_NUM-1:0] cur_onehot;

    // A core that just got its response sits out exactly one IDLE cycle, which
    // covers the cycle in which it is still dropping its old request.
    assign eligible   = (req_bus | wren_bus) & ~cool_mask;
    assign cur_onehot = CORE_NUM'(1) << cur_id;
    assign next_ptr   = (cur_id == ID_W'(CORE_NUM - 1)) ? '0 : cur_id + 1'b1;
    assign wait_last  = (wait_cnt == 3'(READ_LATENCY - 1));

    // Round-robin scan: first eligible core at or after rr_ptr, wrapping.
    always_comb begin
        // NOTE: every variable driven here gets a default first, so no path
        // through the block leaves it unassigned and no latch is inferred.
        grant_valid = 1'b0;
        grant_id    = '0;
        scan_idx    = '0;
        for (int k = 0; k < CORE_NUM; k++) begin
            scan_idx = ID_W'((int'(rr_ptr) + k) % CORE_NUM);
            if (!grant_valid && eligible[scan_idx]) begin
                grant_valid = 1'b1;
                grant_id    = scan_idx;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (!rst_n) state <= S_IDLE;
        else        state <= state_d;
    end

    // Next-state logic; writes skip WAIT.
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:    if (grant_valid) state_d = S_ISSUE;
            S_ISSUE:   state_d = cur_wr ? S_RESPOND : S_WAIT;
            S_WAIT:    if (wait_last) state_d = S_RESPOND;
            S_RESPOND: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Datapath: latch the granted request, drive the memory port, capture read
    // data, pulse the response and advance the round-robin pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr       <= '0;
            cur_id       <= '0;
            cur_wr       <= 1'b0;
            wait_cnt     <= '0;
            cool_mask    <= '0;
            response_bus <= '0;
            readdata     <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_wren     <= 1'b0;
            mem_rden     <= 1'b0;
        end else begin
            // Strobes, response pulse and cooldown are single-cycle by default.
            mem_wren     <= 1'b0;
            mem_rden     <= 1'b0;
            response_bus <= '0;
            cool_mask    <= '0;
            case (state)
                S_IDLE: begin
                    if (grant_valid) begin
                        cur_id    <= grant_id;
                        cur_wr    <= wren_bus[grant_id];
                        mem_addr  <= addr_bus[int'(grant_id)*WIDTH +: WIDTH];
                        mem_wdata <= wdata_bus[int'(grant_id)*WIDTH +: WIDTH];
                        // A core raising both req and wren is served as a write.
                        mem_wren  <= wren_bus[grant_id];
                        mem_rden  <= ~wren_bus[grant_id];
                    end
                end
                S_ISSUE: begin
                    wait_cnt <= '0;
                    if (cur_wr) response_bus <= cur_onehot;
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt + 3'd1;
                    if (wait_last) begin
                        readdata     <= mem_rdata;
                        response_bus <= cur_onehot;
                    end
                end
                S_RESPOND: begin
                    cool_mask <= cur_onehot;
                    rr_ptr    <= next_ptr;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. A transaction-level reference model
// predicts each grant from the sampled requests and pushes the expected memory
// strobe and response into queues; a separate monitor pops and compares them
// whenever the DUT presents a strobe or a response pulse.
module tb_mem_arbiter;

    localparam int WIDTH    = 32;
    localparam int CORE_NUM = 4;
    localparam int RL       = 2;

    logic                      clk;
    logic                      rst_n;
    logic [CORE_NUM-1:0]       req_bus;
    logic [CORE_NUM-1:0]       wren_bus;
    logic [CORE_NUM*WIDTH-1:0] addr_bus;
    logic [CORE_NUM*WIDTH-1:0] wdata_bus;
    logic [CORE_NUM-1:0]       response_bus;
    logic [WIDTH-1:0]          readdata;
    logic [WIDTH-1:0]          mem_addr;
    logic [WIDTH-1:0]          mem_wdata;
    logic                      mem_wren;
    logic                      mem_rden;
    logic [WIDTH-1:0]          mem_rdata;

    mem_arbiter #(
        .WIDTH       (WIDTH),
        .CORE_NUM    (CORE_NUM),
        .READ_LATENCY(RL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_bus     (req_bus),
        .wren_bus    (wren_bus),
        .addr_bus    (addr_bus),
        .wdata_bus   (wdata_bus),
        .response_bus(response_bus),
        .readdata    (readdata),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wren    (mem_wren),
        .mem_rden    (mem_rden),
        .mem_rdata   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int               cyc;
        bit               wr;
        logic [WIDTH-1:0] addr;
        logic [WIDTH-1:0] data;
    } strobe_t;

    typedef struct {
        int               cyc;
        int               id;
        logic [WIDTH-1:0] rd;
    } resp_t;

    strobe_t exp_st[$];
    resp_t   exp_rs[$];

    int n_tests      = 0;
    int n_fail       = 0;
    int cyc          = 0;
    int zero_chk_cyc = -1;

    // Memory behind the port, and the model's own copy of it.
    logic [WIDTH-1:0] tb_mem [64];
    logic [WIDTH-1:0] shadow [64];
    logic             sched_v[8];
    logic [WIDTH-1:0] sched_d[8];

    // Reference model state.
    int               m_ptr      = 0;
    int               m_free     = 0;
    int               m_cool_cyc = -1;
    int               m_cool_id  = 0;
    logic [WIDTH-1:0] m_rd       = '0;

    // Per-core driver state.
    logic [CORE_NUM-1:0] pend = '0;
    int                  gap[CORE_NUM];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference model, evaluated on every rising edge from the sampled inputs.
    // Timing follows from the rules: grant at t, strobe at t+1, response at
    // t+2 (write) or t+2+RL (read), arbitration again the cycle after.
    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            while (exp_st.size() > 0 && exp_st[$].cyc > cyc) void'(exp_st.pop_back());
            while (exp_rs.size() > 0 && exp_rs[$].cyc > cyc) void'(exp_rs.pop_back());
            m_ptr        = 0;
            m_free       = cyc + 1;
            m_cool_cyc   = -1;
            m_rd         = '0;
            zero_chk_cyc = cyc + 1;
        end else if (cyc >= m_free) begin
            int win;
            int i;
            int rc;
            strobe_t s;
            resp_t   r;
            win = -1;
            for (int k = 0; k < CORE_NUM; k++) begin
                i = (m_ptr + k) % CORE_NUM;
                if (win < 0 && (req_bus[i] || wren_bus[i]) &&
                    !(i == m_cool_id && cyc == m_cool_cyc))
                    win = i;
            end
            if (win >= 0) begin
                s.cyc  = cyc + 1;
                s.wr   = wren_bus[win];
                s.addr = addr_bus[win*WIDTH +: WIDTH];
                s.data = wdata_bus[win*WIDTH +: WIDTH];
                rc     = cyc + 2 + (s.wr ? 0 : RL);
                if (s.wr) shadow[s.addr[5:0]] = s.data;
                else      m_rd = shadow[s.addr[5:0]];
                r.cyc = rc;
                r.id  = win;
                r.rd  = m_rd;
                exp_st.push_back(s);
                exp_rs.push_back(r);
                m_free     = rc + 1;
                m_cool_cyc = rc + 1;
                m_cool_id  = win;
                m_ptr      = (win + 1) % CORE_NUM;
            end
        end
    end

    // Monitor and memory responder, on the falling edge.
    initial forever begin
        strobe_t s;
        resp_t   r;
        @(negedge clk);
        cyc = cyc + 1;

        if (cyc == zero_chk_cyc) begin
            check("rst_response_bus", 64'(response_bus), 64'd0);
            check("rst_readdata",     64'(readdata),     64'd0);
            check("rst_mem_addr",     64'(mem_addr),     64'd0);
            check("rst_mem_wdata",    64'(mem_wdata),    64'd0);
            check("rst_mem_wren",     64'(mem_wren),     64'd0);
            check("rst_mem_rden",     64'(mem_rden),     64'd0);
        end

        while (exp_st.size() > 0 && exp_st[0].cyc < cyc) begin
            check("strobe_missing_at_cycle", 64'(cyc), 64'(exp_st[0].cyc));
            void'(exp_st.pop_front());
        end
        while (exp_rs.size() > 0 && exp_rs[0].cyc < cyc) begin
            check("response_missing_at_cycle", 64'(cyc), 64'(exp_rs[0].cyc));
            void'(exp_rs.pop_front());
        end

        if (mem_wren || mem_rden) begin
            check("strobe_exclusive", 64'(mem_wren & mem_rden), 64'd0);
            if (exp_st.size() == 0) begin
                check("unexpected_strobe", 64'(mem_wren | mem_rden), 64'd0);
            end else begin
                s = exp_st.pop_front();
                check("strobe_cycle", 64'(cyc), 64'(s.cyc));
                check("mem_wren", 64'(mem_wren), 64'(s.wr));
                check("mem_rden", 64'(mem_rden), 64'(!s.wr));
                check("mem_addr", 64'(mem_addr), 64'(s.addr));
                if (s.wr) check("mem_wdata", 64'(mem_wdata), 64'(s.data));
            end
        end

        if (response_bus != '0) begin
            if (exp_rs.size() == 0) begin
                check("unexpected_response", 64'(response_bus), 64'd0);
            end else begin
                r = exp_rs.pop_front();
                check("response_cycle", 64'(cyc), 64'(r.cyc));
                check("response_bus", 64'(response_bus), 64'(1) << r.id);
                check("readdata", 64'(readdata), 64'(r.rd));
            end
        end

        // Memory: read data is valid only RL cycles after the rden cycle.
        if (sched_v[cyc % 8]) begin
            mem_rdata           = sched_d[cyc % 8];
            sched_v[cyc % 8]    = 1'b0;
        end else begin
            mem_rdata = $urandom;
        end
        if (mem_rden) begin
            sched_v[(cyc + RL) % 8] = 1'b1;
            sched_d[(cyc + RL) % 8] = tb_mem[mem_addr[5:0]];
        end
        if (mem_wren) tb_mem[mem_addr[5:0]] = mem_wdata;
    end

    task automatic set_core(input int i, input bit rd, input bit wr,
                            input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] d);
        req_bus[i]                  = rd;
        wren_bus[i]                 = wr;
        addr_bus[i*WIDTH +: WIDTH]  = a;
        wdata_bus[i*WIDTH +: WIDTH] = d;
    endtask

    task automatic release_all();
        for (int i = 0; i < CORE_NUM; i++) begin
            set_core(i, 1'b0, 1'b0, '0, '0);
            gap[i] = 0;
        end
        pend = '0;
    endtask

    task automatic wait_resp(input int i, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!response_bus[i] && n < budget);
        check("response_seen", 64'(response_bus[i]), 64'd1);
    endtask

    task automatic wait_rden(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_rden && n < budget);
        check("rden_seen", 64'(mem_rden), 64'd1);
    endtask

    // Randomised traffic. Sticky cores never drop their request; otherwise a
    // core drops after its response, may withdraw early, or may change its
    // address/data while waiting.
    task automatic run_auto(input int cycles, input logic [CORE_NUM-1:0] en,
                            input bit sticky, input int mode, input bit rand_rst);
        int r;
        int t;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            rst_n = 1'b1;
            if (rand_rst && $urandom_range(0, 199) == 0) rst_n = 1'b0;
            for (int i = 0; i < CORE_NUM; i++) begin
                if (pend[i] && !sticky) begin
                    r = $urandom_range(0, 31);
                    if (response_bus[i] || r == 0) begin
                        set_core(i, 1'b0, 1'b0, '0, '0);
                        pend[i] = 1'b0;
                        gap[i]  = $urandom_range(0, 2);
                    end else if (r < 4) begin
                        addr_bus[i*WIDTH +: WIDTH]  = 32'($urandom_range(0, 63));
                        wdata_bus[i*WIDTH +: WIDTH] = $urandom;
                    end
                end else if (!pend[i]) begin
                    if (gap[i] > 0) begin
                        gap[i]--;
                    end else if (en[i] && (sticky || $urandom_range(0, 3) == 0)) begin
                        t = (mode == 1) ? 0 : $urandom_range(0, 2);
                        set_core(i, t != 1, t != 0, 32'($urandom_range(0, 63)), $urandom);
                        pend[i] = 1'b1;
                    end
                end
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        release_all();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            tb_mem[i] = 32'hA500_0000 + 32'(i);
            shadow[i] = 32'hA500_0000 + 32'(i);
        end
        tb_mem[32] = 32'h1234_5678;
        shadow[32] = 32'h1234_5678;
        for (int i = 0; i < 8; i++) begin
            sched_v[i] = 1'b0;
            sched_d[i] = '0;
        end
        rst_n     = 1'b0;
        mem_rdata = '0;
        release_all();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Single write from core 2.
        set_core(2, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
        wait_resp(2, 20);
        set_core(2, 1'b0, 1'b0, '0, '0);
        repeat (2) @(negedge clk);

        // Single read from core 1; memory holds 0x12345678 there.
        set_core(1, 1'b1, 1'b0, 32'h20, '0);
        wait_resp(1, 20);
        set_core(1, 1'b0, 1'b0, '0, '0);
        check("read_result", 64'(readdata), 64'h1234_5678);
        repeat (2) @(negedge clk);

        // Core 3 raises req and wren together: must be a write.
        set_core(3, 1'b1, 1'b1, 32'h05, 32'hCAFE_F00D);
        wait_resp(3, 20);
        set_core(3, 1'b0, 1'b0, '0, '0);
        repeat (2) @(negedge clk);

        // All cores reading continuously straight out of reset.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        run_auto(40, 4'hF, 1'b1, 1, 1'b0);
        repeat (3) @(negedge clk);

        // Only core 0, holding its request through the cooldown cycle.
        run_auto(30, 4'h1, 1'b1, 0, 1'b0);
        repeat (3) @(negedge clk);

        // Reset in the first WAIT cycle of a read, then a fresh arbitration.
        set_core(1, 1'b1, 1'b0, 32'h21, '0);
        wait_rden(20);
        @(negedge clk);
        rst_n = 1'b0;
        set_core(1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        rst_n = 1'b1;
        set_core(1, 1'b1, 1'b0, 32'h22, '0);
        set_core(3, 1'b0, 1'b1, 32'h23, 32'h5555_AAAA);
        wait_resp(1, 20);
        set_core(1, 1'b0, 1'b0, '0, '0);
        wait_resp(3, 20);
        set_core(3, 1'b0, 1'b0, '0, '0);
        repeat (2) @(negedge clk);

        // Random mixed traffic with occasional resets.
        run_auto(2000, 4'hF, 1'b0, 0, 1'b1);

        // Let anything in flight complete, then confirm nothing is outstanding.
        repeat (30) @(negedge clk);
        check("strobes_outstanding", 64'(exp_st.size()), 64'd0);
        check("responses_outstanding", 64'(exp_rs.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish before 500000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, data and address width.
REQ-002 The block SHALL have parameter CORE_NUM, default 4, number of core ports; legal range 2..8.
REQ-003 The block SHALL have parameter READ_LATENCY, default 2, cycles from mem_rden to valid mem_rdata; legal range 1..4.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic on posedge.
REQ-005 The block SHALL have port rst_n, input, 1, the reset, which is synchronous and active-low.
REQ-006 The block SHALL have port req_bus, input, CORE_NUM, per-core read request (core i = bit i).
REQ-007 The block SHALL have port wren_bus, input, CORE_NUM, per-core write request.
REQ-008 The block SHALL have port addr_bus, input, CORE_NUM*WIDTH, per-core address (core i = bits [i*WIDTH +: WIDTH]).
REQ-009 The block SHALL have port wdata_bus, input, CORE_NUM*WIDTH, per-core write data, same packing as addr_bus.
REQ-010 The block SHALL have port response_bus, output, CORE_NUM, per-core one-cycle completion pulse.
REQ-011 The block SHALL have port readdata, output, WIDTH, read result broadcast to all cores.
REQ-012 The block SHALL have ports mem_addr (output, WIDTH), mem_wdata (output, WIDTH), mem_wren (output, 1), mem_rden (output, 1) and mem_rdata (input, WIDTH), forming the single memory port.

Function
REQ-013 The block SHALL implement the FSM IDLE -> ISSUE -> WAIT (reads only) -> RESPOND -> IDLE, with writes going ISSUE -> RESPOND.
REQ-014 Core i SHALL be pending when req_bus[i] or wren_bus[i] is 1; if both are 1, the transaction SHALL be a write.
REQ-015 In IDLE, the block SHALL grant the first eligible pending core at or after rr_ptr, scanning upward modulo CORE_NUM, and SHALL latch the core id, address, wdata and type at that edge.
REQ-016 In IDLE with no eligible pending core, the block SHALL stay in IDLE and drive no memory strobe.
REQ-017 ISSUE SHALL last exactly 1 cycle and drive mem_addr/mem_wdata from the latched values, with mem_wren=1 for a write or mem_rden=1 for a read.
REQ-018 The block SHALL assert mem_wren and mem_rden only in ISSUE and SHALL never assert both together.
REQ-019 WAIT SHALL last READ_LATENCY cycles, and the block SHALL capture mem_rdata into readdata at the edge ending the last WAIT cycle.
REQ-020 RESPOND SHALL last 1 cycle with response_bus[id]=1 and all other response bits 0; rr_ptr SHALL become (id+1) mod CORE_NUM.
REQ-021 Timing, for a grant in IDLE cycle t: a write SHALL have mem_wren at t+1 and response at t+2; a read SHALL have mem_rden at t+1 and response at t+2+READ_LATENCY.
REQ-022 readdata SHALL hold its value until the next read capture, and writes SHALL NOT modify it.
REQ-023 The core that received a response in cycle r SHALL be ineligible in cycle r+1 (cooldown covering the core's one-cycle request drop), and other cores SHALL remain eligible in r+1.
REQ-024 A pending transaction, once granted, SHALL run to completion with a response pulse even if the core deasserts its request mid-transaction.
REQ-025 Request changes on non-granted cores during a transaction SHALL be ignored until the next IDLE.
REQ-026 The block SHALL run at most one transaction at a time, with no pipelining or overlap.
REQ-027 The rr_ptr increment SHALL wrap from CORE_NUM-1 to 0.

Reset
REQ-028 With rst_n=0 at a posedge, the block SHALL set state=IDLE, rr_ptr=0, response_bus=0, readdata=0, mem_wren=0, mem_rden=0, mem_addr=0, mem_wdata=0 and clear the cooldown mask.
REQ-029 A reset during ISSUE, WAIT or RESPOND SHALL abort the transaction with no response pulse, and strobes SHALL be 0 from the cycle after the reset edge.
REQ-030 The block SHALL grant nothing in the cycle rst_n=0 is sampled; arbitration SHALL resume on the first edge with rst_n=1.

Verification
REQ-031 A single write must complete: core 2 wren=1, addr=0x10, wdata=0xDEADBEEF at t -> mem_wren=1, mem_addr=0x10 at t+1, response_bus=4'b0100 at t+2, readdata unchanged.
REQ-032 A single read must return data: core 1 req=1, addr=0x20, memory returns 0x12345678 with READ_LATENCY=2 -> mem_rden at t+1, response_bus=4'b0010 and readdata=0x12345678 at t+4.
REQ-033 Round-robin must rotate: all 4 cores issue reads continuously from reset -> grant order 0,1,2,3,0 and no core granted twice in a row.
REQ-034 Cooldown must hold: only core 0 is requesting and holds req for 1 cycle after its response -> no second grant in cycle r+1, and a new grant only if req is still 1 at r+2.
REQ-035 Simultaneous request types must resolve to a write: core 3 has req=1 and wren=1 -> write issued, with mem_rden=0 throughout.
REQ-036 Reset mid-read must abort cleanly: rst_n=0 during WAIT -> no response pulse, all outputs 0 next cycle, and a fresh request after reset is granted from rr_ptr=0.
